sync_fifo2: RTL and testbench
=============================

SYNC_FIFO2 -- requirements
Module: sync_fifo2

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR_SIZE, default 8, address width; depth DEPTH = 2**ADDR_SIZE.
REQ-003 SHALL have parameter AFULL_THRESH, default DEPTH-4, level at or above which wr_almost_full asserts.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 4, level at or below which rd_almost_empty asserts.
REQ-005 SHALL have parameter FWFT, default 0; 0 = standard read, 1 = first-word-fall-through.
REQ-006 SHALL have ports: clk in 1 single clock; rst in 1 reset (one clock; reset is asynchronous and active-high).
REQ-007 SHALL have ports: flush in 1 sync clear; wr_inc in 1 write request; wr_data in DATA_SIZE write word.
REQ-008 SHALL have ports: rd_inc in 1 read request; rd_data out DATA_SIZE read word.
REQ-009 SHALL have ports: wr_full, wr_almost_full, rd_empty, rd_almost_empty, overflow, underflow, each out 1; level out ADDR_SIZE+1 occupancy.

Function
REQ-010 SHALL accept a write iff wr_inc && !wr_full && !flush; the word is stored at the write pointer, which advances by 1 and wraps from DEPTH-1 to 0.
REQ-011 SHALL accept a read iff rd_inc && !rd_empty && !flush; the read pointer advances by 1 and wraps from DEPTH-1 to 0.
REQ-012 SHALL keep pointers ADDR_SIZE+1 bits wide; full = MSBs differ and lower bits equal; empty = pointers equal.
REQ-013 SHALL register all flags and level; they reflect accepted operations one cycle after the clk edge.
REQ-014 SHALL update level +1 on write only, -1 on read only, and leave it unchanged on simultaneous accepted write and read.
REQ-015 SHALL, when full with wr_inc && rd_inc: accept the read, reject the write, and set overflow; level becomes DEPTH-1.
REQ-016 SHALL, when empty with wr_inc && rd_inc: accept the write, reject the read, and set underflow; level becomes 1.
REQ-017 SHALL set overflow (sticky) on wr_inc while wr_full, and underflow (sticky) on rd_inc while rd_empty; each clears only on rst or flush.
REQ-018 SHALL assert wr_almost_full iff level >= AFULL_THRESH and rd_almost_empty iff level <= AEMPTY_THRESH.
REQ-019 SHALL, with FWFT=0, register rd_data from the head entry on an accepted read (1-cycle latency) and hold it otherwise.
REQ-020 SHALL, with FWFT=1, drive rd_data combinationally from the head entry whenever !rd_empty; an accepted read advances to the next entry.
REQ-021 SHALL, with flush high, zero pointers, level and sticky flags on the next edge, set rd_empty=1 and wr_full=0, ignore wr_inc and rd_inc, and leave memory contents undefined.
REQ-022 SHALL not reset memory contents.

Reset
REQ-023 SHALL, on rst assertion and independent of clk, force pointers=0, level=0, rd_empty=1, rd_almost_empty=1, wr_full=0, wr_almost_full=0, overflow=0, underflow=0, and registered rd_data=0.
REQ-024 SHALL, on rst asserted mid-operation, discard all stored words; the first accepted write after release is read first.
REQ-025 SHALL accept operations on the first clk edge after rst deasserts.

Structure
REQ-026 SHALL take FIFO mode encoding (FWFT/standard enum) and flag-threshold helper constants from the shared fifo package.
REQ-027 SHALL instantiate one sub-module, sync_fifo_ram: DEPTH x DATA_SIZE, one write port and one async read port, no reset.
REQ-028 SHALL keep pointer, level and flag logic in sync_fifo2 itself; no clock-domain crossing logic.

Verification (ADDR_SIZE=2, DEPTH=4, DATA_SIZE=8, AFULL_THRESH=3, AEMPTY_THRESH=1)
REQ-029 SHALL write 0x11,0x22,0x33,0x44 then read 4 (FWFT=0) -> wr_full=1 after the 4th write, level=4, reads return 0x11..0x44, rd_empty=1 at end.
REQ-030 SHALL write a 5th word 0x55 when full -> rejected, overflow=1 and stays 1, level=4, data order unchanged.
REQ-031 SHALL assert wr_inc and rd_inc together when full -> read returns 0x11, level=3, wr_full=0, overflow=1; when empty -> write accepted, underflow=1, level=1.
REQ-032 SHALL run 10 write/read pairs crossing wrap (pointers pass 3->0) -> data in order, level never exceeds 4.
REQ-033 SHALL use FWFT=1, write 0xA5 into empty -> rd_empty=0 next cycle and rd_data=0xA5 with no rd_inc.
REQ-034 SHALL apply flush at level=3 with wr_inc=1, and separately rst mid-burst -> level=0, rd_empty=1, overflow=0, underflow=0, and the concurrent write is dropped.

Source files
------------

// File: rtl/sync_fifo2_pkg.sv
// Shared FIFO definitions: read-mode encoding and flag-threshold helpers.
package sync_fifo2_pkg;

   // Read-side behaviour of the FIFO
   typedef enum logic {
      FIFO_STD  = 1'b0,   // registered read data, one cycle after rd_inc
      FIFO_FWFT = 1'b1    // head word visible whenever the FIFO is not empty
   } fifo_mode_e;

   // Default low-water mark for rd_almost_empty
   localparam int AEMPTY_DEFAULT = 4;

   // Default high-water mark for wr_almost_full: four words below depth
   function automatic int afull_default(input int addr_size);
      return (1 << addr_size) - 4;
   endfunction

   // Maps the integer FWFT parameter onto the mode enum
   function automatic fifo_mode_e fifo_mode(input int fwft);
      return (fwft != 0) ? FIFO_FWFT : FIFO_STD;
   endfunction

endpackage

// File: rtl/sync_fifo2_ram.sv
// FIFO storage: DEPTH x DATA_SIZE, one synchronous write port, one
// asynchronous read port. Contents are never reset.
module sync_fifo_ram #(
   parameter int DATA_SIZE = 8,
   parameter int ADDR_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [ADDR_SIZE-1:0] wr_addr,
   input  logic [DATA_SIZE-1:0] wr_data,
   input  logic [ADDR_SIZE-1:0] rd_addr,
   output logic [DATA_SIZE-1:0] rd_data
);

   localparam int DEPTH = 1 << ADDR_SIZE;

   logic [DATA_SIZE-1:0] mem [DEPTH];

   // Store the write word at the write address
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo2.sv
// Single-clock FIFO with registered flags/level, sticky overflow/underflow,
// synchronous flush and selectable standard or first-word-fall-through read.
module sync_fifo2
   import sync_fifo2_pkg::*;
#(
   parameter int DATA_SIZE     = 8,
   parameter int ADDR_SIZE     = 8,
   parameter int AFULL_THRESH  = afull_default(ADDR_SIZE),
   parameter int AEMPTY_THRESH = AEMPTY_DEFAULT,
   parameter int FWFT          = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 wr_inc,
   input  logic [DATA_SIZE-1:0] wr_data,
   input  logic                 rd_inc,
   output logic [DATA_SIZE-1:0] rd_data,
   output logic                 wr_full,
   output logic                 wr_almost_full,
   output logic                 rd_empty,
   output logic                 rd_almost_empty,
   output logic                 overflow,
   output logic                 underflow,
   output logic [ADDR_SIZE:0]   level
);

   localparam fifo_mode_e       MODE       = fifo_mode(FWFT);
   localparam logic [ADDR_SIZE:0] AFULL_LVL  = AFULL_THRESH[ADDR_SIZE:0];
   localparam logic [ADDR_SIZE:0] AEMPTY_LVL = AEMPTY_THRESH[ADDR_SIZE:0];
   localparam logic [ADDR_SIZE:0] ONE        = {{ADDR_SIZE{1'b0}}, 1'b1};

   logic [ADDR_SIZE:0]   wr_ptr, rd_ptr;
   logic [ADDR_SIZE:0]   wr_ptr_nxt, rd_ptr_nxt, level_nxt;
   logic                 wr_en, rd_en;
   logic                 overflow_nxt, underflow_nxt;
   logic [DATA_SIZE-1:0] head;

   // Accept/reject decisions and next pointer, level and sticky-flag values
   always_comb begin
      wr_en         = wr_inc && !wr_full  && !flush;
      rd_en         = rd_inc && !rd_empty && !flush;
      wr_ptr_nxt    = wr_ptr;
      rd_ptr_nxt    = rd_ptr;
      level_nxt     = level;
      overflow_nxt  = overflow;
      underflow_nxt = underflow;
      if (flush) begin
         wr_ptr_nxt    = '0;
         rd_ptr_nxt    = '0;
         level_nxt     = '0;
         overflow_nxt  = 1'b0;
         underflow_nxt = 1'b0;
      end else begin
         if (wr_en) wr_ptr_nxt = wr_ptr + ONE;
         if (rd_en) rd_ptr_nxt = rd_ptr + ONE;
         case ({wr_en, rd_en})
            2'b10:   level_nxt = level + ONE;
            2'b01:   level_nxt = level - ONE;
            default: level_nxt = level;
         endcase
         if (wr_inc && wr_full)  overflow_nxt  = 1'b1;
         if (rd_inc && rd_empty) underflow_nxt = 1'b1;
      end
   end

   // Pointers, level and all flags, registered from their next values
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         level           <= '0;
         wr_full         <= 1'b0;
         wr_almost_full  <= 1'b0;
         rd_empty        <= 1'b1;
         rd_almost_empty <= 1'b1;
         overflow        <= 1'b0;
         underflow       <= 1'b0;
      end else begin
         wr_ptr          <= wr_ptr_nxt;
         rd_ptr          <= rd_ptr_nxt;
         level           <= level_nxt;
         wr_full         <= (wr_ptr_nxt[ADDR_SIZE] != rd_ptr_nxt[ADDR_SIZE]) &&
                            (wr_ptr_nxt[ADDR_SIZE-1:0] == rd_ptr_nxt[ADDR_SIZE-1:0]);
         rd_empty        <= (wr_ptr_nxt == rd_ptr_nxt);
         wr_almost_full  <= (level_nxt >= AFULL_LVL);
         rd_almost_empty <= (level_nxt <= AEMPTY_LVL);
         overflow        <= overflow_nxt;
         underflow       <= underflow_nxt;
      end
   end

   sync_fifo_ram #(
      .DATA_SIZE (DATA_SIZE),
      .ADDR_SIZE (ADDR_SIZE)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr[ADDR_SIZE-1:0]),
      .wr_data (wr_data),
      .rd_addr (rd_ptr[ADDR_SIZE-1:0]),
      .rd_data (head)
   );

   if (MODE == FIFO_FWFT) begin : g_fwft
      // Head word shown directly; zero while empty so stale storage never leaks out
      assign rd_data = rd_empty ? '0 : head;
   end else begin : g_std
      logic [DATA_SIZE-1:0] rd_q;

      // Capture the head word on an accepted read, hold otherwise
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rd_q <= '0;
         end else if (rd_en) begin
            rd_q <= head;
         end
      end

      assign rd_data = rd_q;
   end

endmodule

// File: tb/tb_sync_fifo2.sv
// Scoreboard bench for sync_fifo2: a standard-read and an FWFT instance
// share one stimulus stream and are checked against a queue model.
module tb_sync_fifo2;

   localparam int DW    = 8;
   localparam int AW    = 2;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst, flush, wr_inc, rd_inc;
   logic [DW-1:0] wr_data;

   logic [DW-1:0] rd_data_s, rd_data_f;
   logic          full_s, afull_s, empty_s, aempty_s, ovf_s, udf_s;
   logic          full_f, afull_f, empty_f, aempty_f, ovf_f, udf_f;
   logic [AW:0]   level_s, level_f;

   int            vectors     = 0;
   int            miscompares = 0;
   logic [DW-1:0] q[$];
   logic          m_ovf, m_udf;
   logic [DW-1:0] last_rd;

   always #5 clk = ~clk;

   sync_fifo2 #(
      .DATA_SIZE(DW), .ADDR_SIZE(AW), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(0)
   ) u_std (
      .clk(clk), .rst(rst), .flush(flush), .wr_inc(wr_inc), .wr_data(wr_data),
      .rd_inc(rd_inc), .rd_data(rd_data_s), .wr_full(full_s), .wr_almost_full(afull_s),
      .rd_empty(empty_s), .rd_almost_empty(aempty_s), .overflow(ovf_s),
      .underflow(udf_s), .level(level_s)
   );

   sync_fifo2 #(
      .DATA_SIZE(DW), .ADDR_SIZE(AW), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(1)
   ) u_fwft (
      .clk(clk), .rst(rst), .flush(flush), .wr_inc(wr_inc), .wr_data(wr_data),
      .rd_inc(rd_inc), .rd_data(rd_data_f), .wr_full(full_f), .wr_almost_full(afull_f),
      .rd_empty(empty_f), .rd_almost_empty(aempty_f), .overflow(ovf_f),
      .underflow(udf_f), .level(level_f)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Flags packed as {full, almost_full, empty, almost_empty, overflow, underflow}
   task automatic check_state();
      int         lvl;
      logic [5:0] exp_flags;
      lvl       = q.size();
      exp_flags = {lvl == DEPTH, lvl >= 3, lvl == 0, lvl <= 1, m_ovf, m_udf};
      check("level_std",  level_s, lvl);
      check("level_fwft", level_f, lvl);
      check("flags_std",  {full_s, afull_s, empty_s, aempty_s, ovf_s, udf_s}, exp_flags);
      check("flags_fwft", {full_f, afull_f, empty_f, aempty_f, ovf_f, udf_f}, exp_flags);
      if (lvl > 0) check("fwft_head", rd_data_f, q[0]);
   endtask

   task automatic step(input logic wr, input logic [DW-1:0] wd, input logic rd, input logic fl);
      bit wa, ra;
      wr_inc  = wr;
      wr_data = wd;
      rd_inc  = rd;
      flush   = fl;
      wa = wr && (q.size() < DEPTH) && !fl;
      ra = rd && (q.size() > 0) && !fl;
      if (fl) begin
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         if (wr && q.size() == DEPTH) m_ovf = 1'b1;
         if (rd && q.size() == 0)     m_udf = 1'b1;
      end
      @(posedge clk);
      #1;
      if (fl) q.delete();
      if (ra) last_rd = q.pop_front();
      if (wa) q.push_back(wd);
      check("std_rdata", rd_data_s, last_rd);
      check_state();
      wr_inc = 1'b0;
      rd_inc = 1'b0;
      flush  = 1'b0;
   endtask

   // Asynchronous reset asserted mid-cycle, optionally with a write pending
   task automatic do_reset(input logic wr);
      wr_inc  = wr;
      wr_data = 8'hEE;
      #3;
      rst = 1'b1;
      #1;
      q.delete();
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      last_rd = '0;
      check("rst_rdata", rd_data_s, 0);
      check_state();
      @(posedge clk);
      #1;
      rst    = 1'b0;
      wr_inc = 1'b0;
      check_state();
   endtask

   initial begin
      logic [DW-1:0] words [4];
      logic [DW-1:0] r;
      words   = '{8'h11, 8'h22, 8'h33, 8'h44};
      rst     = 1'b1;
      flush   = 1'b0;
      wr_inc  = 1'b0;
      rd_inc  = 1'b0;
      wr_data = '0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      last_rd = '0;
      #2;
      check("rst_rdata", rd_data_s, 0);
      check_state();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Fill to full, then overflow attempt
      foreach (words[i]) step(1'b1, words[i], 1'b0, 1'b0);
      step(1'b1, 8'h55, 1'b0, 1'b0);
      // Simultaneous write/read while full: read wins, write dropped
      step(1'b1, 8'h66, 1'b1, 1'b0);
      repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);
      // Simultaneous write/read while empty: write wins, underflow
      step(1'b1, 8'h77, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Streaming pairs across pointer wrap
      r = 8'($urandom);
      step(1'b1, r, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         r = 8'($urandom);
         step(1'b1, r, 1'b1, 1'b0);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Fall-through of a single word into an empty FIFO
      step(1'b1, 8'hA5, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Flush at level 3 with a concurrent write
      step(1'b1, 8'hC1, 1'b0, 1'b0);
      step(1'b1, 8'hC2, 1'b0, 1'b0);
      step(1'b1, 8'hC3, 1'b0, 1'b0);
      step(1'b1, 8'hC4, 1'b1, 1'b1);
      step(1'b1, 8'hD1, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Reset in the middle of a burst
      step(1'b1, 8'hE1, 1'b0, 1'b0);
      step(1'b1, 8'hE2, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      do_reset(1'b1);
      step(1'b1, 8'hF1, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
